// File: rtl/vortex_ctrl_axil.sv
// AXI4-Lite control slave for the Vortex wrapper: owns the core reset, the DCR
// write port, start/done sequencing and a run-time cycle counter.
module vortex_ctrl_axil #(
    parameter int AXIL_ADDR_WIDTH = 8,
    parameter int DCR_ADDR_WIDTH  = 12,
    parameter int DCR_DATA_WIDTH  = 32,
    parameter int RESET_CYCLES    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       s_axil_awvalid,
    output logic                       s_axil_awready,
    input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                       s_axil_wvalid,
    output logic                       s_axil_wready,
    input  logic [31:0]                s_axil_wdata,
    input  logic [3:0]                 s_axil_wstrb,
    output logic                       s_axil_bvalid,
    input  logic                       s_axil_bready,
    output logic [1:0]                 s_axil_bresp,
    input  logic                       s_axil_arvalid,
    output logic                       s_axil_arready,
    input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
    output logic                       s_axil_rvalid,
    input  logic                       s_axil_rready,
    output logic [31:0]                s_axil_rdata,
    output logic [1:0]                 s_axil_rresp,
    output logic                       vx_reset,
    output logic                       dcr_wr_valid,
    output logic [DCR_ADDR_WIDTH-1:0]  dcr_wr_addr,
    output logic [DCR_DATA_WIDTH-1:0]  dcr_wr_data,
    input  logic                       vx_busy,
    output logic                       irq
);
    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_STATUS   = 3'd1;
    localparam logic [2:0] REG_DCR_ADDR = 3'd2;
    localparam logic [2:0] REG_DCR_DATA = 3'd3;
    localparam logic [2:0] REG_CYCLES   = 3'd4;
    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [7:0] RESET_LAST   = 8'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_LAUNCH = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [7:0]                rst_cnt_q;
    logic                      live_q;
    logic                      aw_full_q, w_full_q;
    logic [2:0]                aw_sel_q;
    logic [31:0]               wdata_q;
    logic [3:0]                wstrb_q;
    logic [DCR_ADDR_WIDTH-1:0] dcr_addr_q;
    logic [31:0]               cycles_q;
    logic                      done_q;

    logic wr_exec, wr_commit, is_idle;
    logic start_req, start_ok, clear_req, dcr_req, dcr_ok, dcr_addr_wr, run_done;
    logic unused_addr_bits;

    // Only bits [4:2] decode; the rest of each address is ignored.
    assign unused_addr_bits = ^{s_axil_awaddr[1:0], s_axil_awaddr[AXIL_ADDR_WIDTH-1:5],
                                s_axil_araddr[1:0], s_axil_araddr[AXIL_ADDR_WIDTH-1:5]};

    assign is_idle     = (state_q == ST_IDLE);
    assign wr_exec     = aw_full_q && w_full_q;
    assign wr_commit   = wr_exec && (wstrb_q == 4'hF);
    assign start_req   = wr_commit && (aw_sel_q == REG_CTRL) && wdata_q[0];
    assign clear_req   = wr_commit && (aw_sel_q == REG_CTRL) && wdata_q[1];
    assign start_ok    = start_req && is_idle;
    assign dcr_req     = wr_commit && (aw_sel_q == REG_DCR_DATA);
    assign dcr_ok      = dcr_req && is_idle;
    assign dcr_addr_wr = wr_commit && (aw_sel_q == REG_DCR_ADDR);
    assign run_done    = (state_q == ST_RUN) && !vx_busy;

    assign s_axil_awready = live_q && !aw_full_q && !s_axil_bvalid;
    assign s_axil_wready  = live_q && !w_full_q && !s_axil_bvalid;
    assign s_axil_arready = live_q && !s_axil_rvalid;
    assign s_axil_rresp   = RESP_OKAY;
    assign vx_reset       = (state_q == ST_RESET) || (state_q == ST_IDLE);
    assign irq            = done_q;

    function automatic logic [31:0] read_mux(input logic [2:0] sel);
        logic [31:0] val;
        val = '0;
        case (sel)
            REG_STATUS:   val = {28'd0, state_q, done_q, vx_busy};
            REG_DCR_ADDR: val = 32'(dcr_addr_q);
            REG_DCR_DATA: val = 32'(dcr_wr_data);
            REG_CYCLES:   val = cycles_q;
            default:      val = '0;
        endcase
        return val;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_RESET;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  if (rst_cnt_q == RESET_LAST) state_d = ST_IDLE;
            ST_IDLE:   if (start_ok) state_d = ST_LAUNCH;
            ST_LAUNCH: if (vx_busy) state_d = ST_RUN;
            ST_RUN:    if (!vx_busy) state_d = ST_RESET;
            default:   state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_cnt_q <= '0;
            live_q    <= 1'b0;
            cycles_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            live_q    <= 1'b1;
            rst_cnt_q <= (state_q == ST_RESET && state_d == ST_RESET) ? rst_cnt_q + 8'd1 : 8'd0;
            if (start_ok)
                cycles_q <= '0;
            else if (state_q == ST_RUN && cycles_q != '1)
                cycles_q <= cycles_q + 32'd1;
            // Completion takes priority over a coincident clear.
            if (run_done)
                done_q <= 1'b1;
            else if (start_ok || clear_req)
                done_q <= 1'b0;
        end
    end

    // Write channel: AW and W slots fill independently, execute once both are full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aw_full_q     <= 1'b0;
            w_full_q      <= 1'b0;
            aw_sel_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= RESP_OKAY;
            dcr_addr_q    <= '0;
            dcr_wr_valid  <= 1'b0;
            dcr_wr_addr   <= '0;
            dcr_wr_data   <= '0;
        end else begin
            if (s_axil_awvalid && s_axil_awready) begin
                aw_full_q <= 1'b1;
                aw_sel_q  <= s_axil_awaddr[4:2];
            end
            if (s_axil_wvalid && s_axil_wready) begin
                w_full_q <= 1'b1;
                wdata_q  <= s_axil_wdata;
                wstrb_q  <= s_axil_wstrb;
            end
            if (wr_exec) begin
                aw_full_q     <= 1'b0;
                w_full_q      <= 1'b0;
                s_axil_bvalid <= 1'b1;
                s_axil_bresp  <= ((start_req && !is_idle) || (dcr_req && !is_idle)) ? RESP_SLVERR : RESP_OKAY;
            end else if (s_axil_bvalid && s_axil_bready) begin
                s_axil_bvalid <= 1'b0;
            end
            if (dcr_addr_wr)
                dcr_addr_q <= wdata_q[DCR_ADDR_WIDTH-1:0];
            dcr_wr_valid <= dcr_ok;
            if (dcr_ok) begin
                dcr_wr_addr <= dcr_addr_q;
                dcr_wr_data <= wdata_q;
            end
        end
    end

    // Read channel: data is captured at the AR handshake, so it reflects pre-write state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= '0;
        end else if (s_axil_arvalid && s_axil_arready) begin
            s_axil_rvalid <= 1'b1;
            s_axil_rdata  <= read_mux(s_axil_araddr[4:2]);
        end else if (s_axil_rvalid && s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vortex_ctrl_axil.sv
// Directed bench for vortex_ctrl_axil: register vector table plus hand-timed
// sequences for start/run/done, channel ordering, backpressure and reset corners.
module tb_vortex_ctrl_axil;
    logic        clk, reset;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [7:0]  awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        vx_reset, dcr_wr_valid, vx_busy, irq;
    logic [11:0] dcr_wr_addr;
    logic [31:0] dcr_wr_data;

    int checks = 0;
    int failures = 0;
    int dcr_cnt = 0;
    logic [11:0] dcr_last_addr = '0;
    logic [31:0] dcr_last_data = '0;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[16];

    vortex_ctrl_axil dut (
        .clk(clk), .reset(reset),
        .s_axil_awvalid(awvalid), .s_axil_awready(awready), .s_axil_awaddr(awaddr),
        .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
        .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_bresp(bresp),
        .s_axil_arvalid(arvalid), .s_axil_arready(arready), .s_axil_araddr(araddr),
        .s_axil_rvalid(rvalid), .s_axil_rready(rready), .s_axil_rdata(rdata), .s_axil_rresp(rresp),
        .vx_reset(vx_reset), .dcr_wr_valid(dcr_wr_valid), .dcr_wr_addr(dcr_wr_addr),
        .dcr_wr_data(dcr_wr_data), .vx_busy(vx_busy), .irq(irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (dcr_wr_valid) begin
            dcr_cnt       <= dcr_cnt + 1;
            dcr_last_addr <= dcr_wr_addr;
            dcr_last_data <= dcr_wr_data;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int  n;
        bit  aw_hs, w_hs;
        n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        while ((awvalid || wvalid) && n < 50) begin
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bvalid_arrives", 32'(bvalid), 32'd1);
        resp = bresp;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d);
        int n;
        n = 0;
        araddr = a; arvalid = 1'b1;
        @(negedge clk);
        while (!arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rvalid_arrives", 32'(rvalid), 32'd1);
        d = rdata;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    logic [31:0] rd, first;
    logic [1:0]  resp, resp2;
    logic        bad;

    initial begin
        reset = 1'b1; vx_busy = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;

        vecs[0]  = '{1'b0, 8'h04, 32'h0,        4'hF, 32'h4,        "status_idle"};
        vecs[1]  = '{1'b0, 8'h00, 32'h0,        4'hF, 32'h0,        "ctrl_reads_zero"};
        vecs[2]  = '{1'b0, 8'h10, 32'h0,        4'hF, 32'h0,        "cycles_reset"};
        vecs[3]  = '{1'b0, 8'h08, 32'h0,        4'hF, 32'h0,        "dcr_addr_reset"};
        vecs[4]  = '{1'b1, 8'h08, 32'h1,        4'hF, 32'h0,        "wr_dcr_addr_okay"};
        vecs[5]  = '{1'b0, 8'h08, 32'h0,        4'hF, 32'h1,        "rd_dcr_addr"};
        vecs[6]  = '{1'b1, 8'h08, 32'hABC,      4'h3, 32'h0,        "partial_strb_okay"};
        vecs[7]  = '{1'b0, 8'h08, 32'h0,        4'hF, 32'h1,        "partial_strb_ignored"};
        vecs[8]  = '{1'b1, 8'h0C, 32'h80000000, 4'hF, 32'h0,        "wr_dcr_data_okay"};
        vecs[9]  = '{1'b0, 8'h0C, 32'h0,        4'hF, 32'h80000000, "rd_dcr_data"};
        vecs[10] = '{1'b0, 8'h14, 32'h0,        4'hF, 32'h0,        "unmapped_read"};
        vecs[11] = '{1'b1, 8'h1C, 32'hFFFFFFFF, 4'hF, 32'h0,        "unmapped_write_okay"};
        vecs[12] = '{1'b0, 8'h08, 32'h0,        4'hF, 32'h1,        "unmapped_write_no_effect"};
        vecs[13] = '{1'b1, 8'h00, 32'h1,        4'h3, 32'h0,        "start_partial_strb_okay"};
        vecs[14] = '{1'b0, 8'h04, 32'h0,        4'hF, 32'h4,        "still_idle"};
        vecs[15] = '{1'b1, 8'h0C, 32'h1234,     4'h0, 32'h0,        "dcr_data_zero_strb_okay"};

        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vx_reset", 32'(vx_reset), 32'd1);
        chk("rst_readies", {29'd0, awready, wready, arready}, 32'd0);
        chk("rst_valids", {28'd0, bvalid, rvalid, dcr_wr_valid, irq}, 32'd0);
        chk("rst_resps", {28'd0, bresp, rresp}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_dcr_port", 32'(dcr_wr_addr) | dcr_wr_data, 32'd0);
        reset = 1'b1;

        // 16th counting edge still sees RESET; the next one sees IDLE.
        repeat (15) @(posedge clk);
        #1;
        axi_read(8'h04, rd);
        chk("status_last_reset_cycle", rd, 32'h0);
        axi_read(8'h04, rd);
        chk("status_idle_after_reset", rd, 32'h4);
        chk("vx_reset_in_idle", 32'(vx_reset), 32'd1);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
                chk(vecs[i].name, 32'(resp), vecs[i].exp);
            end else begin
                axi_read(vecs[i].addr, rd);
                chk(vecs[i].name, rd, vecs[i].exp);
            end
        end
        chk("dcr_pulse_count", 32'(dcr_cnt), 32'd1);
        chk("dcr_pulse_addr", 32'(dcr_last_addr), 32'h1);
        chk("dcr_pulse_data", dcr_last_data, 32'h80000000);

        // W five cycles ahead of AW, then hold off bready.
        wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        chk("w_slot_full_ready", {30'd0, wready, awready}, 32'b01);
        repeat (4) @(posedge clk);
        #1;
        chk("no_bvalid_w_only", 32'(bvalid), 32'd0);
        awaddr = 8'h08; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        chk("no_bvalid_exec_cycle", 32'(bvalid), 32'd0);
        @(posedge clk); #1;
        chk("bvalid_after_both", {29'd0, bvalid, bresp}, 32'b100);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (awready || wready || !bvalid) bad = 1'b1;
        end
        chk("bready_backpressure", 32'(bad), 32'd0);
        @(posedge clk); #1;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("single_response", 32'(bvalid), 32'd0);

        // Read data held stable under rready backpressure.
        araddr = 8'h08; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        first = rdata;
        chk("rd_after_ordering", first, 32'h55);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (arready || !rvalid || rdata !== first) bad = 1'b1;
        end
        chk("rready_backpressure", 32'(bad), 32'd0);
        @(posedge clk); #1;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        chk("rvalid_released", 32'(rvalid), 32'd0);

        // Start write and STATUS read land in the same execute cycle.
        awaddr = 8'h00; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 8'h04; arvalid = 1'b1;
        chk("vx_reset_before_exec", 32'(vx_reset), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        chk("vx_reset_falls", 32'(vx_reset), 32'd0);
        chk("status_pre_start", {rdata[30:0], rvalid}, {32'h4 << 1} | 32'd1);
        chk("start_bresp", {29'd0, bvalid, bresp}, 32'b100);
        bready = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0; rready = 1'b0;

        repeat (2) @(posedge clk);
        #1 vx_busy = 1'b1;
        fork
            begin
                repeat (100) @(posedge clk);
                #1 vx_busy = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                axi_write(8'h00, 32'h1, 4'hF, resp2);
                chk("start_in_run_slverr", 32'(resp2), 32'd2);
                axi_read(8'h04, rd);
                chk("status_run_unchanged", rd, 32'hD);
                axi_write(8'h0C, 32'hDEAD, 4'hF, resp2);
                chk("dcr_in_run_slverr", 32'(resp2), 32'd2);
                chk("no_dcr_pulse_in_run", 32'(dcr_cnt), 32'd1);
            end
        join
        chk("irq_before_done", 32'(irq), 32'd0);
        @(posedge clk); #1;
        chk("irq_on_done", {30'd0, irq, vx_reset}, 32'b11);
        axi_read(8'h10, rd);
        chk("cycles_100", rd, 32'd100);
        axi_read(8'h04, rd);
        chk("status_done_reset", rd, 32'h2);
        repeat (20) @(posedge clk);
        #1;
        axi_read(8'h04, rd);
        chk("status_done_idle", rd, 32'h6);
        axi_write(8'h00, 32'h2, 4'hF, resp);
        chk("clear_done_okay", 32'(resp), 32'd0);
        chk("irq_cleared", 32'(irq), 32'd0);
        axi_read(8'h04, rd);
        chk("status_after_clear", rd, 32'h4);

        // Second run: clear-done executes on the same edge busy is seen low.
        axi_write(8'h00, 32'h1, 4'hF, resp);
        chk("start2_okay", 32'(resp), 32'd0);
        vx_busy = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        awaddr = 8'h00; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; vx_busy = 1'b0; bready = 1'b1;
        chk("irq_low_before_tie", 32'(irq), 32'd0);
        @(posedge clk); #1;
        chk("done_wins_tie", {29'd0, irq, bvalid, bresp[1]}, 32'b110);
        @(posedge clk); #1;
        bready = 1'b0;
        chk("done_kept", 32'(irq), 32'd1);
        axi_read(8'h10, rd);
        chk("cycles_run2", rd, 32'd6);

        // Third run: system reset asserted mid-RUN.
        repeat (20) @(posedge clk);
        #1;
        axi_write(8'h00, 32'h2, 4'hF, resp);
        axi_write(8'h08, 32'h123, 4'hF, resp);
        axi_write(8'h00, 32'h1, 4'hF, resp);
        chk("start3_okay", 32'(resp), 32'd0);
        vx_busy = 1'b1;
        repeat (10) @(posedge clk);
        chk("vx_reset_low_in_run", 32'(vx_reset), 32'd0);
        #3 reset = 1'b0;
        #1;
        chk("async_vx_reset", 32'(vx_reset), 32'd1);
        chk("async_clear_outputs", {28'd0, bvalid, rvalid, dcr_wr_valid, irq}, 32'd0);
        vx_busy = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        axi_read(8'h04, rd);
        chk("reset_len_16_idle", rd, 32'h4);
        axi_read(8'h10, rd);
        chk("cycles_cleared_by_reset", rd, 32'd0);
        axi_read(8'h08, rd);
        chk("dcr_addr_cleared_by_reset", rd, 32'd0);
        axi_read(8'h0C, rd);
        chk("dcr_data_cleared_by_reset", rd, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
